pulse_stretch_driver: RTL and testbench
=======================================

Name: pulse_stretch_driver

Overview:
Output-side counterpart to the board input conditioner. It accepts single-cycle event ticks from internal logic and turns each one into a visible fixed-width pulse on a board output such as an LED or buzzer. A guaranteed low gap separates consecutive pulses. Ticks that arrive while a pulse is in progress are queued in a saturating counter, so N ticks produce N distinct pulses, up to the queue depth.

Parameters:
ON_CYCLES, 12_500_000, high time of each output pulse in clk cycles (>=1)
OFF_CYCLES, 12_500_000, minimum low gap after each pulse in clk cycles (>=1)
PEND_W, 4, width of pending-event counter; queue depth = 2**PEND_W-1

Ports:
clk  input  1  system clock
rst  input  1  reset
tick  input  1  event strobe; each high cycle is one event
pulse_out  output  1  stretched pulse; registered, glitch-free
busy  output  1  high whenever state != IDLE
pending  output  PEND_W  queued events not yet started
drop  output  1  one-cycle strobe: tick discarded because queue full

Interface (decided): one clock, clk; rst is synchronous and active-high. All state updates occur on the rising edge of clk only; no other clock or gated clock exists.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, timer=0, pending=0, pulse_out=0, busy=0, drop=0.
  - rst overrides tick in the same cycle.
  - Reset mid-pulse truncates the pulse immediately: pulse_out=0 on the next cycle and queued events are lost.
- States: IDLE, ON, OFF. timer width = clog2(max(ON_CYCLES,OFF_CYCLES))+1; it counts down to 0.
- pulse_out is exactly (state==ON), registered. busy is exactly (state!=IDLE).
- IDLE:
  - tick=1 -> ON, timer=ON_CYCLES-1. pending unchanged; the event is consumed directly.
  - tick=0 -> stay in IDLE. pending is always 0 in IDLE.
- ON:
  - timer==0 -> OFF, timer=OFF_CYCLES-1.
  - Otherwise timer decrements.
  - pulse_out is high for exactly ON_CYCLES consecutive cycles.
- OFF:
  - timer==0 and (pending>0 or tick=1) -> ON, timer=ON_CYCLES-1, and one event is consumed.
  - timer==0 otherwise -> IDLE.
  - Otherwise timer decrements.
- Latency: tick high during the cycle before edge k in IDLE gives pulse_out=1 from just after edge k, i.e. one cycle of latency.
- Pending counter, evaluated per edge in ON/OFF:
  - inc = tick
  - dec = consume at the end of OFF with pending>0
  - inc&dec -> unchanged
  - inc only -> +1
  - dec only -> -1
  - At the end of OFF with pending==0 and tick=1, the tick is consumed directly and pending stays 0.
- Saturation: pending==2**PEND_W-1, inc=1 and dec=0 -> pending holds and drop=1 for that one cycle. drop is 0 otherwise; it is not sticky.
- Minimum period between pulse rising edges = ON_CYCLES+OFF_CYCLES. Back-to-back queued pulses occur at exactly that period.
- Multi-cycle tick: each high cycle counts as a separate event. Callers drive one-cycle strobes.
- No arithmetic wrap is permitted on pending or timer.

Test Plan:
(All with ON_CYCLES=3, OFF_CYCLES=2, PEND_W=2, so queue depth = 3.)
1. Reset, then a single 1-cycle tick at cycle 10:
   - pulse_out=1 on cycles 11-13, then 0.
   - busy=1 on cycles 11-15.
   - IDLE at cycle 16, pending stays 0.
2. Ticks at cycles 10, 12 and 13:
   - pending goes 1 then 2.
   - Pulses start at cycles 11, 16 and 21, each 3 cycles wide.
   - pending=0 after cycle 16+5; returns to IDLE at cycle 26.
3. Ticks on 5 consecutive cycles starting at cycle 10:
   - The first starts a pulse; pending saturates at 3.
   - The 5th tick gives drop=1 for exactly one cycle.
   - Exactly 4 pulses are emitted.
4. A tick on the same cycle OFF expires with pending=1:
   - pending stays 1.
   - The next pulse starts immediately, with no IDLE cycle.
5. rst=1 asserted during the 2nd cycle of ON with pending=2:
   - The next cycle shows pulse_out=0, pending=0, busy=0.
   - A tick coinciding with rst is ignored.
6. A tick arriving exactly on the cycle the OFF timer reaches 0 with pending=0:
   - A new pulse starts on the next cycle; pending stays 0 and drop stays 0.

Source files
------------

// File: rtl/pulse_stretch_driver.sv
// Turns single-cycle event ticks into fixed-width output pulses with a guaranteed low gap.
// Ticks that arrive while a pulse is in progress are queued in a saturating counter.
module pulse_stretch_driver #(
    parameter int ON_CYCLES  = 12_500_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    output logic              pulse_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              drop
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]     OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0]     TIMER_ONE = TW'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF
    } state_t;

    state_t            r_state;
    logic [TW-1:0]     r_timer;
    logic [PEND_W-1:0] r_pending;
    logic              r_pulse;
    logic              r_busy;
    logic              r_drop;

    logic w_offDone;
    logic w_inc;
    logic w_dec;

    // A tick landing exactly at the end of OFF with nothing queued is consumed
    // directly by the new pulse, so it never touches the pending counter.
    assign w_offDone = (r_state == S_OFF) && (r_timer == '0);
    assign w_inc     = tick && (r_state != S_IDLE) && !(w_offDone && (r_pending == '0));
    assign w_dec     = w_offDone && (r_pending != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_pending <= '0;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tick) begin
                        r_state <= S_ON;
                        r_timer <= ON_LOAD;
                        r_pulse <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (r_timer == '0) begin
                        r_state <= S_OFF;
                        r_timer <= OFF_LOAD;
                        r_pulse <= 1'b0;
                    end else begin
                        r_timer <= r_timer - TIMER_ONE;
                    end
                end
                S_OFF: begin
                    if (r_timer == '0) begin
                        if ((r_pending != '0) || tick) begin
                            r_state <= S_ON;
                            r_timer <= ON_LOAD;
                            r_pulse <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase

            // Saturating queue: a tick that would overflow is discarded and flagged.
            if (w_inc && !w_dec) begin
                if (r_pending == PEND_MAX) begin
                    r_drop <= 1'b1;
                end else begin
                    r_pending <= r_pending + PEND_ONE;
                end
            end else if (w_dec && !w_inc) begin
                r_pending <= r_pending - PEND_ONE;
            end
        end
    end

    assign pulse_out = r_pulse;
    assign busy      = r_busy;
    assign pending   = r_pending;
    assign drop      = r_drop;

endmodule

// File: tb/tb_pulse_stretch_driver.sv
// Bench for pulse_stretch_driver: directed scenarios plus random ticks, checked against
// a schedule model where every accepted event is assigned its pulse start cycle.
module tb_pulse_stretch_driver;

    localparam int ON     = 3;
    localparam int OFF    = 2;
    localparam int PEND_W = 2;
    localparam int PERIOD = ON + OFF;
    localparam int QMAX   = (1 << PEND_W) - 1;

    logic              clk;
    logic              rst;
    logic              tick;
    logic              pulseOut;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              drop;

    int checks;
    int passes;
    int cyc;
    int lastStart;
    int starts[$];
    logic modelDrop;

    pulse_stretch_driver #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .PEND_W    (PEND_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .pulse_out(pulseOut),
        .busy     (busy),
        .pending  (pending),
        .drop     (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
        end else begin
            passes++;
        end
    endtask

    function automatic int countAfter(input int n);
        int cnt = 0;
        foreach (starts[i]) if (starts[i] > n) cnt++;
        return cnt;
    endfunction

    function automatic logic activeWithin(input int n, input int width);
        logic hit = 1'b0;
        foreach (starts[i]) if (starts[i] <= n && n < starts[i] + width) hit = 1'b1;
        return hit;
    endfunction

    // Each event starts a pulse at the later of its own edge or one full period
    // after the previous pulse; events still waiting for their start are "pending".
    task automatic updateModel(input logic t, input logic r);
        int s;
        modelDrop = 1'b0;
        if (r) begin
            starts.delete();
            lastStart = -1000;
        end else if (t) begin
            s = (cyc > lastStart + PERIOD) ? cyc : lastStart + PERIOD;
            if (s > cyc && countAfter(cyc) + 1 > QMAX) begin
                modelDrop = 1'b1;
            end else begin
                starts.push_back(s);
                lastStart = s;
            end
        end
        while (starts.size() > 0 && starts[0] + PERIOD <= cyc) void'(starts.pop_front());
    endtask

    task automatic applyStimulus(input logic t, input logic r);
        tick = t;
        rst  = r;
        @(posedge clk);
        cyc++;
        updateModel(t, r);
        #1;
        checkOutput("pulse_out", 32'(pulseOut), 32'(activeWithin(cyc, ON)));
        checkOutput("busy", 32'(busy), 32'(activeWithin(cyc, PERIOD)));
        checkOutput("pending", 32'(pending), 32'(countAfter(cyc)));
        checkOutput("drop", 32'(drop), 32'(modelDrop));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        int dens;
        checks    = 0;
        passes    = 0;
        cyc       = 0;
        lastStart = -1000;
        modelDrop = 1'b0;
        tick      = 1'b0;
        rst       = 1'b1;

        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        idle(4);

        // single tick
        applyStimulus(1'b1, 1'b0);
        idle(8);

        // ticks queue behind a running pulse
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        idle(20);

        // five consecutive ticks saturate the queue and drop one
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        idle(28);

        // tick lands as OFF expires with one event already queued
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        idle(7);
        applyStimulus(1'b1, 1'b0);
        idle(16);

        // reset mid-pulse with a coincident tick
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
        idle(3);
        applyStimulus(1'b1, 1'b1);
        idle(6);

        // tick exactly at OFF expiry with an empty queue
        applyStimulus(1'b1, 1'b0);
        idle(4);
        applyStimulus(1'b1, 1'b0);
        idle(8);

        dens = 30;
        for (int i = 0; i < 900; i++) begin
            if (i % 100 == 0) dens = $urandom_range(5, 80);
            applyStimulus(($urandom_range(0, 99) < dens) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0);
        end
        idle(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
